// File: rtl/pipelined_subtractor.sv
// Pipelined N-bit subtractor (Diff = A - B - Bin) split into STAGES ripple-borrow chunks,
// with a valid/ready handshake and a single global advance enable.
module pipelined_subtractor #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
);

    localparam int W = N / STAGES;

    // Per stage: operand copies travelling with the op, partially built result, borrow, valid.
    logic [N-1:0] a_q  [STAGES];
    logic [N-1:0] b_q  [STAGES];
    logic [N-1:0] d_q  [STAGES];
    logic         br_q [STAGES];
    logic         v_q  [STAGES];

    logic [N-1:0] a_n  [STAGES];
    logic [N-1:0] b_n  [STAGES];
    logic [N-1:0] d_n  [STAGES];
    logic         br_n [STAGES];
    logic         v_n  [STAGES];

    logic adv;

    function automatic logic [W:0] chunk_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bi);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    endfunction

    assign out_valid = v_q[STAGES-1];
    assign Diff      = d_q[STAGES-1];
    assign Bout      = br_q[STAGES-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    always_comb begin
        logic [W:0] sub;
        sub = chunk_sub(A[W-1:0], B[W-1:0], Bin);
        a_n[0]  = A;
        b_n[0]  = B;
        d_n[0]  = '0;
        d_n[0][W-1:0] = sub[W-1:0];
        br_n[0] = sub[W];
        v_n[0]  = in_valid & in_ready;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sub = chunk_sub(a_q[k-1][k*W +: W], b_q[k-1][k*W +: W], br_q[k-1]);
            a_n[k]  = a_q[k-1];
            b_n[k]  = b_q[k-1];
            // Lower chunks come from the previous stage; only chunk k is new here.
            d_n[k]  = d_q[k-1];
            d_n[k][k*W +: W] = sub[W-1:0];
            br_n[k] = sub[W];
            v_n[k]  = v_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                d_q[k]  <= '0;
                br_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_n[k];
                b_q[k]  <= b_n[k];
                d_q[k]  <= d_n[k];
                br_q[k] <= br_n[k];
                v_q[k]  <= v_n[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor (N=8, STAGES=2): driver pushes expected
// results at accept, monitor pops and compares on every output handshake.
module tb_pipelined_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Diff;
    logic       Bout;

    pipelined_subtractor #(.N(8), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Bout(Bout)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    bit         ov_log [16384];
    logic [8:0] exp_q [$];
    bit         rand_rdy = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: ov_log[c] is out_valid after posedge number c.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (cyc < 16384) ov_log[cyc] = out_valid;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got Bout=%0d Diff=%0d expected no output", Bout, Diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({Bout, Diff} !== e) begin
                        n_bad++;
                        $display("FAIL result: got Bout=%0d Diff=%0d expected Bout=%0d Diff=%0d",
                                 Bout, Diff, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge (number acc).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, output int acc);
        int tries = 0;
        bit done = 0;
        A = a; B = b; Bin = bi; in_valid = 1'b1; acc = -1;
        while (!done && tries < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({eb, ed});
                acc = cyc + 1;
                done = 1;
            end
            @(posedge clk);
            #2;
            tries++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    initial begin
        int e0, e1, e2, e3;
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] m;
        int w;

        reset = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
        #12;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_diff", 32'(Diff), 0);
        check("reset_bout", 32'(Bout), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single op: latency 2 edges, then idle
        send(8'd20, 8'd10, 1'b0, 8'd10, 1'b0, e0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("first_accept_edge", 32'(e0), 3);
        check("lat_before", 32'(ov_log[e0]), 0);
        check("lat_valid", 32'(ov_log[e0+1]), 1);
        check("lat_after", 32'(ov_log[e0+2]), 0);
        align();

        // Back-to-back, including inter-chunk borrow
        send(8'd0,   8'd1,   1'b0, 8'd255, 1'b1, e0);
        send(8'd128, 8'd128, 1'b1, 8'd255, 1'b1, e1);
        send(8'd255, 8'd0,   1'b1, 8'd254, 1'b0, e2);
        send(8'h10,  8'h01,  1'b0, 8'h0F,  1'b0, e3);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("b2b_accept_span", 32'(e3 - e0), 3);
        for (int i = 1; i <= 4; i++) check("b2b_no_gap", 32'(ov_log[e0+i]), 1);
        check("b2b_end", 32'(ov_log[e0+5]), 0);
        align();

        // Bubble
        send(8'd50, 8'd25, 1'b0, 8'd25, 1'b0, e0);
        in_valid = 1'b0;
        align();
        send(8'd7, 8'd9, 1'b0, 8'd254, 1'b1, e1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("bubble_accept_gap", 32'(e1 - e0), 2);
        check("bubble_first", 32'(ov_log[e0+1]), 1);
        check("bubble_hole", 32'(ov_log[e0+2]), 0);
        check("bubble_second", 32'(ov_log[e0+3]), 1);
        align();

        // Stall with backpressure
        out_ready = 1'b0;
        fork
            begin
                send(8'd200, 8'd100, 1'b0, 8'd100, 1'b0, e0);
                send(8'd3,   8'd5,   1'b1, 8'd253, 1'b1, e1);
                send(8'h80,  8'h7F,  1'b0, 8'd1,   1'b0, e2);
                in_valid = 1'b0;
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 20);
                check("stall_first_valid", 32'(out_valid), 1);
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_out_valid", 32'(out_valid), 1);
                    check("stall_diff", 32'(Diff), 100);
                    check("stall_bout", 32'(Bout), 0);
                    check("stall_in_ready", 32'(in_ready), 0);
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        check("stall_drained", 32'(exp_q.size()), 0);
        align();

        // Asynchronous reset with two ops in flight
        send(8'd9,   8'd4, 1'b0, 8'd5,  1'b0, e0);
        send(8'd100, 8'd1, 1'b0, 8'd99, 1'b0, e1);
        check("pre_reset_valid", 32'(out_valid), 1);
        check("pre_reset_diff", 32'(Diff), 5);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_diff", 32'(Diff), 0);
        check("async_rst_bout", 32'(Bout), 0);
        in_valid = 1'b0;
        exp_q.delete();
        align();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_output", 32'(out_valid), 0);
        end
        align();

        // Random operands with random output backpressure
        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            m   = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            send(ra, rb, rbi, m[7:0], m[8], e0);
        end
        in_valid = 1'b0;
        align();
        rand_rdy = 0;
        out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("final_drain", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
Pipelined N-bit subtractor: Diff = A - B - Bin, with borrow out Bout. It is the inverse-direction counterpart of pipelined_adder and shares its chunked ripple-borrow pipeline structure (N split into STAGES equal chunks, one chunk per stage). It adds a valid/ready handshake with global stall so the ALU datapath can backpressure it.

Parameters:
N, 8, operand/result width in bits
STAGES, 2, pipeline depth; N must be divisible by STAGES; chunk width W = N/STAGES

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  A/B/Bin valid this cycle
in_ready  output  1  block accepts the operand when in_valid & in_ready
A  input  N  minuend
B  input  N  subtrahend
Bin  input  1  borrow in
out_valid  output  1  Diff/Bout valid
out_ready  input  1  downstream consumes the result when out_valid & out_ready
Diff  output  N  (A - B - Bin) mod 2^N
Bout  output  1  1 iff A < B + Bin (unsigned)

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, chunk registers, borrow registers, Diff, Bout and out_valid go to 0 immediately. In-flight operations are discarded, not completed. Release is sampled synchronously; the first accept can occur on the first rising edge with reset=1.
- Advance enable: adv = out_ready | ~out_valid. in_ready = adv, combinational. There is no bubble collapsing: a bubble in an interior stage still advances only when adv=1.
- When adv=0 (stall), every register holds its value. Diff, Bout and out_valid remain stable while out_valid=1 and out_ready=0.
- Stage k (k = 0..STAGES-1), on adv:
  - Computes chunk k difference as A[k] - B[k] - borrow_in_k over W+1 bits.
  - borrow_in_0 = Bin. borrow_in_k = borrow out of stage k-1 (registered).
  - The registered chunk result is the low W bits. The registered borrow is 1 iff the (W+1)-bit result is negative.
- Skew handling:
  - Upper operand chunks are delayed so they reach stage k exactly k cycles after accept.
  - Lower result chunks are delayed so all chunks of one operation appear together.
- Stage valid: v0 <= in_valid & in_ready; vk <= v(k-1) on adv. out_valid = v(STAGES-1).
- Latency: exactly STAGES accepted-edge advances from accept to out_valid. With no stall, an operand accepted at edge t is presented after edge t+STAGES-1, i.e. 2 cycles for the default.
- Throughput: one operation per cycle when out_ready is held 1.
- Bout = final-stage borrow out. Bin=1 with A == B gives Diff = 2^N - 1 and Bout = 1.
- Accept and output handshake in the same cycle: legal. The output is consumed and the pipeline shifts with no lost or duplicated result.
- in_valid=0 on an adv cycle inserts a bubble. Data registers may update, but the matching valid bit is 0.
- Operands are captured only at accept; A/B/Bin are don't-care otherwise.

Test Plan:
- Reset then A=20, B=10, Bin=0, one accept, out_ready=1 -> exactly 2 edges later out_valid=1, Diff=10, Bout=0, then out_valid=0.
- Back-to-back accepts (0,1,0), (128,128,1), (255,0,1), (0x10,0x01,0), one per cycle, out_ready=1 -> consecutive outputs in order: 255/1, 255/1, 254/0, 0x0F/0 (the last checks the inter-chunk borrow); no gaps.
- Stall: issue 3 operations, drop out_ready for 4 cycles after the first out_valid -> in_ready=0 during the stall, Diff/Bout/out_valid held constant, then all 3 results delivered in order after release with no loss or duplication.
- Bubble: accept (50,25,0), idle 1 cycle, accept (7,9,0) -> outputs 25/0, one out_valid=0 cycle, then 254/1.
- Reset mid-flight: 2 operations in the pipe, pulse reset low between edges -> out_valid, Diff and Bout go to 0 without waiting for a clock edge; no stale result appears after release.
- Random check: 1000 random A/B/Bin with a random out_ready pattern -> every output matches the reference model ((A-B-Bin) mod 256, A < B+Bin) in issue order.
